gray_mem_arbiter: RTL and testbench
===================================

// Module: gray_mem_arbiter
// PURPOSE
//   Shares the single gray-image memory read port (req/ready/addr/data, data one cycle after
//   accepted request) between two requesters: port 0 = LBP engine window fetch, port 1 =
//   secondary reader (e.g. host readback/histogram). Round-robin ownership with burst locking,
//   so one 3x3 window fetch of 9 beats stays contiguous. Read data is routed back to the owner.
// PARAMETERS
//   ADDR_W     14  memory address width ({row[6:0], col[6:0]})
//   DATA_W     8   pixel width
//   MAX_BURST  9   max accepted beats per ownership while the other port is waiting
// PORTS
//   clk        in   1       rising-edge clock
//   reset      in   1       synchronous, active-high
//   req0/req1  in   1       requester read request, held until beat accepted
//   addr0/addr1 in  ADDR_W  requester read address
//   gnt0/gnt1  out  1       port owns memory this cycle
//   rvalid0/1  out  1       read data valid for that port
//   rdata0/1   out  DATA_W  read data
//   mem_req    out  1       to memory: request
//   mem_addr   out  ADDR_W  to memory: address
//   mem_ready  in   1       memory accepts request this cycle
//   mem_data   in   DATA_W  memory data, valid cycle after acceptance
//   busy       out  1       any port owns memory or a read return is pending
// BEHAVIOUR
//   - Reset (sync, high): state IDLE, last_owner=1 (port 0 wins first tie), burst_cnt=0,
//     rvalid0/1=0, rdata0/1=0, pending return dropped. gnt*, mem_req, mem_addr are
//     combinational from state: all 0 in IDLE. busy=0.
//   - States: IDLE, OWN0, OWN1. gnt_i = (state==OWN_i).
//   - IDLE: any req high -> next OWN_i; if both, the port != last_owner. burst_cnt<=0.
//     No memory request issued in IDLE (1 cycle arbitration latency from req to mem_req).
//   - OWN_i: mem_req=req_i, mem_addr=addr_i. Beat accepted = req_i & mem_ready;
//     accepted beat increments burst_cnt (saturates at MAX_BURST).
//   - Leaving OWN_i (evaluated each cycle, last_owner<=i on exit, burst_cnt<=0):
//       req_i low                                -> OWN_other if req_other else IDLE
//       accepted beat & burst_cnt==MAX_BURST-1 & req_other -> OWN_other (forced switch)
//       otherwise stay; with req_other low ownership is unlimited.
//   - Handover is direct OWN0<->OWN1, no IDLE bubble; new owner may issue same cycle it
//     enters its state.
//   - Return path: on accepted beat in OWN_i, register ret_port=i, ret_pend=1. Next cycle
//     rvalid_i=1, rdata_i=mem_data (registered output, so data visible 1 cycle after
//     mem_data, 2 after acceptance); other port rvalid=0, rdata holds last value.
//     Returns are attributed by ret_port even if ownership switched meanwhile.
//   - Requester rules: beat is consumed only when gnt_i & mem_ready; addr_i must be stable
//     while req_i high and ungranted. Arbiter never reorders beats of one port.
//   - mem_ready low: owner stalls, burst_cnt unchanged, no switch (stall not a beat).
//   - Simultaneous req drop and forced switch: req_i low takes precedence (same target).
//   - Reset mid-burst: immediate IDLE, outstanding return discarded (no rvalid after reset).
//   - busy = (state!=IDLE) | ret_pend | rvalid0 | rvalid1.
// STRUCTURE
//   - Shared package lbp_pkg: ADDR_W/DATA_W constants, arb_state_t {IDLE,OWN0,OWN1},
//     row/col address pack helper.
//   - One sub-module: arb_rr_sel (comb 2-way round-robin pick from req vector + last_owner).
//   - Top holds state reg, burst counter, last_owner, return-tag pipeline, output regs.
// TESTING
//   1 Reset then req0 only, addr0=14'h0081, mem_ready=1 -> gnt0 next cycle, mem_addr=0x0081,
//     rvalid0 two cycles after acceptance with rdata0=mem_data; rvalid1 stays 0.
//   2 req0,req1 rise together after reset -> OWN0 first; after req0 drops -> OWN1, no IDLE gap.
//   3 Both hold req continuously -> exactly 9 accepted beats per ownership, alternating
//     0,1,0; per-port data order matches address order 0..8.
//   4 mem_ready low 3 cycles mid-burst -> no beats counted, no switch, burst resumes at cnt.
//   5 req1 only, req0 never -> burst of 20 beats uninterrupted (lock unlimited when alone).
//   6 reset asserted 1 cycle after accepted beat -> no rvalid, state IDLE, gnt0=gnt1=0,
//     next tie goes to port 0.

Source files
------------

// File: rtl/lbp_pkg.sv
// lbp_pkg -- shared constants and types for the gray-image memory arbiter.
//   LBP_ADDR_W / LBP_DATA_W : gray-image memory address ({row,col}) and pixel widths
//   LBP_MAX_BURST           : beats one owner may take while the other port waits
//   arb_state_t             : arbiter ownership state
//   pack_addr()             : build a memory address from row/col
//   own_state()             : ownership state for a port index
package lbp_pkg;

    localparam int LBP_ROW_W     = 7;
    localparam int LBP_COL_W     = 7;
    localparam int LBP_ADDR_W    = LBP_ROW_W + LBP_COL_W;
    localparam int LBP_DATA_W    = 8;
    localparam int LBP_MAX_BURST = 9;   // one 3x3 window fetch

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    function automatic logic [LBP_ADDR_W-1:0] pack_addr(
        input logic [LBP_ROW_W-1:0] row,
        input logic [LBP_COL_W-1:0] col
    );
        return {row, col};
    endfunction

    function automatic arb_state_t own_state(input logic port);
        return port ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/arb_rr_sel.sv
// arb_rr_sel -- combinational 2-way round-robin pick.
//   req        in   2   request vector {req1, req0}
//   last_owner in   1   port that owned the memory most recently
//   any        out  1   at least one request present
//   pick       out  1   selected port index (valid when any=1)
module arb_rr_sel (
    input  logic [1:0] req,
    input  logic       last_owner,
    output logic       any,
    output logic       pick
);

    // On a tie the port that did not own last wins; otherwise the lone requester.
    assign any  = |req;
    assign pick = (&req) ? ~last_owner : req[1];

endmodule

// File: rtl/gray_mem_arbiter.sv
// gray_mem_arbiter -- shares the gray-image memory read port between the LBP
// window fetcher (port 0) and a secondary reader (port 1). Round-robin ownership
// with burst locking so a 9-beat window fetch stays contiguous; read data is
// routed back to the port that issued the beat.
//   clk, reset          clock, synchronous active-high reset
//   req0/1, addr0/1     requester read request (held until accepted) and address
//   gnt0/1              port owns the memory this cycle
//   rvalid0/1, rdata0/1 registered read return, 2 cycles after acceptance
//   mem_req, mem_addr   request/address to memory
//   mem_ready           memory accepts the request this cycle
//   mem_data            memory data, valid the cycle after acceptance
//   busy                ownership held or a return still in flight
module gray_mem_arbiter
    import lbp_pkg::*;
#(
    parameter int ADDR_W    = LBP_ADDR_W,
    parameter int DATA_W    = LBP_DATA_W,
    parameter int MAX_BURST = LBP_MAX_BURST
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic [ADDR_W-1:0] addr0,
    input  logic              req1,
    input  logic [ADDR_W-1:0] addr1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic [DATA_W-1:0] rdata0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata1,
    output logic              mem_req,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [DATA_W-1:0] mem_data,
    output logic              busy
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);

    arb_state_t       state;
    logic             last_owner;
    logic [CNT_W-1:0] burst_cnt;
    logic             ret_pend;
    logic             ret_port;

    logic own_idx, own_req, oth_req, beat, burst_end, leave;
    logic pick_any, pick_port;

    arb_rr_sel u_sel (
        .req        ({req1, req0}),
        .last_owner (last_owner),
        .any        (pick_any),
        .pick       (pick_port)
    );

    assign gnt0 = (state == OWN0);
    assign gnt1 = (state == OWN1);

    always_comb begin
        mem_req  = 1'b0;
        mem_addr = '0;
        case (state)
            OWN0: begin
                mem_req  = req0;
                mem_addr = addr0;
            end
            OWN1: begin
                mem_req  = req1;
                mem_addr = addr1;
            end
            default: ;
        endcase
    end

    assign own_idx = gnt1;
    assign own_req = gnt1 ? req1 : req0;
    assign oth_req = gnt1 ? req0 : req1;
    assign beat    = mem_req & mem_ready;

    // >= rather than == so an owner that ran past the limit while alone still
    // hands over on its next beat once the other port starts asking.
    assign burst_end = beat && (burst_cnt >= CNT_W'(MAX_BURST - 1));

    // A dropped request and a forced switch both go to the same target, so the
    // drop simply wins by being folded into the same exit.
    assign leave = ~own_req | (burst_end & oth_req);

    assign busy = (state != IDLE) | ret_pend | rvalid0 | rvalid1;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            last_owner <= 1'b1;
            burst_cnt  <= '0;
            ret_pend   <= 1'b0;
            ret_port   <= 1'b0;
            rvalid0    <= 1'b0;
            rvalid1    <= 1'b0;
            rdata0     <= '0;
            rdata1     <= '0;
        end else begin
            // Return tag travels with the beat so data lands on the issuing port
            // even if ownership has already moved on.
            ret_pend <= beat;
            if (beat)
                ret_port <= own_idx;

            rvalid0 <= ret_pend & ~ret_port;
            rvalid1 <= ret_pend &  ret_port;
            if (ret_pend & ~ret_port)
                rdata0 <= mem_data;
            if (ret_pend & ret_port)
                rdata1 <= mem_data;

            case (state)
                IDLE: begin
                    burst_cnt <= '0;
                    if (pick_any)
                        state <= own_state(pick_port);
                end
                OWN0, OWN1: begin
                    if (leave) begin
                        last_owner <= own_idx;
                        burst_cnt  <= '0;
                        state      <= oth_req ? own_state(~own_idx) : IDLE;
                    end else if (beat && burst_cnt != CNT_W'(MAX_BURST)) begin
                        burst_cnt <= burst_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gray_mem_arbiter.sv
// tb_gray_mem_arbiter -- directed bench for gray_mem_arbiter: single-port
// latency, tie/handover, burst locking, mem_ready stalls, unlimited lone
// ownership and reset mid-burst. Memory model returns addr[7:0]^8'hA5.
module tb_gray_mem_arbiter;
    import lbp_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1;
    logic [13:0] addr0, addr1;
    logic        gnt0, gnt1;
    logic        rvalid0, rvalid1;
    logic [7:0]  rdata0, rdata1;
    logic        mem_req;
    logic [13:0] mem_addr;
    logic        mem_ready;
    logic [7:0]  mem_data;
    logic        busy;

    int n_chk  = 0;
    int n_pass = 0;

    bit         beat_q[$];
    logic [7:0] ret0_q[$];
    logic [7:0] ret1_q[$];

    always #5 clk = ~clk;

    gray_mem_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .addr0     (addr0),
        .req1      (req1),
        .addr1     (addr1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rdata0    (rdata0),
        .rvalid1   (rvalid1),
        .rdata1    (rdata1),
        .mem_req   (mem_req),
        .mem_addr  (mem_addr),
        .mem_ready (mem_ready),
        .mem_data  (mem_data),
        .busy      (busy)
    );

    // memory: data for an accepted address appears the following cycle
    always @(posedge clk)
        if (mem_req && mem_ready)
            mem_data <= mem_addr[7:0] ^ 8'hA5;

    // record accepted beats (owner) and returns per port
    always @(negedge clk) begin
        if (!reset) begin
            if (mem_req && mem_ready) beat_q.push_back(gnt1);
            if (rvalid0) ret0_q.push_back(rdata0);
            if (rvalid1) ret1_q.push_back(rdata1);
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0;
        addr0 = '0;  addr1 = '0;
        mem_ready = 1'b1;
        tick(); tick();
        reset = 1'b0;
        beat_q.delete(); ret0_q.delete(); ret1_q.delete();
    endtask

    // Hold requests until nbeats are accepted; each port's address advances by
    // one per accepted beat. mem_ready drops for stall_len cycles once
    // stall_at beats have been taken; ownership must not move during the stall.
    task automatic run_beats(input bit r0, input bit r1, input int nbeats,
                             input int stall_at, input int stall_len,
                             input logic [13:0] a0, input logic [13:0] a1);
        int  cyc = 0;
        int  stalled = 0;
        bit  acc, port;
        addr0 = a0; addr1 = a1;
        req0 = r0;  req1 = r1;
        while (beat_q.size() < nbeats && cyc < 500) begin
            if (beat_q.size() == stall_at && stalled < stall_len) begin
                mem_ready = 1'b0;
                stalled++;
                #1;
                chk($sformatf("stall_own_%0d", stalled), {gnt1, gnt0}, 2'b01);
            end else begin
                mem_ready = 1'b1;
                #1;
            end
            acc  = mem_req && mem_ready;
            port = gnt1;
            tick();
            if (acc) begin
                if (port) addr1 = addr1 + 14'd1;
                else      addr0 = addr0 + 14'd1;
            end
            cyc++;
        end
        if (cyc >= 500) chk("run_timeout", 1, 0);
        req0 = 1'b0; req1 = 1'b0; mem_ready = 1'b1;
        repeat (4) tick();
    endtask

    initial begin
        int errs;
        bit exp_own;

        // ---- 1: single port latency --------------------------------------
        do_reset();
        chk("rst_gnt",    {gnt1, gnt0}, 2'b00);
        chk("rst_memreq", mem_req, 0);
        chk("rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("rst_rdata0", rdata0, 8'h00);
        chk("rst_busy",   busy, 0);
        req0 = 1'b1; addr0 = 14'h0081;
        #1;
        chk("t1_idle_noreq", mem_req, 0);
        tick();
        chk("t1_gnt",      {gnt1, gnt0}, 2'b01);
        chk("t1_memreq",   mem_req, 1);
        chk("t1_memaddr",  mem_addr, 14'h0081);
        tick();                              // beat accepted on this edge
        req0 = 1'b0;
        #1;
        chk("t1_rv_early", rvalid0, 0);
        chk("t1_busy",     busy, 1);
        tick();
        chk("t1_rvalid0",  rvalid0, 1);
        chk("t1_rdata0",   rdata0, 8'h24);
        chk("t1_rvalid1",  rvalid1, 0);
        tick();
        chk("t1_rv_single", rvalid0, 0);
        chk("t1_rd_hold",   rdata0, 8'h24);
        chk("t1_idle_busy", busy, 0);

        // ---- 2: tie after reset, direct handover -------------------------
        do_reset();
        req0 = 1'b1; req1 = 1'b1; addr0 = 14'h0100; addr1 = 14'h02C3;
        tick();
        chk("t2_first_own", {gnt1, gnt0}, 2'b01);
        chk("t2_addr0",     mem_addr, 14'h0100);
        tick();                              // port 0 beat accepted
        req0 = 1'b0;
        #1;
        chk("t2_drop_noreq", mem_req, 0);
        tick();
        chk("t2_handover",  {gnt1, gnt0}, 2'b10);
        chk("t2_addr1",     mem_addr, 14'h02C3);
        chk("t2_rvalid0",   rvalid0, 1);
        chk("t2_rdata0",    rdata0, 8'hA5);
        tick();                              // port 1 beat accepted
        req1 = 1'b0;
        tick();
        chk("t2_rvalid1",   rvalid1, 1);
        chk("t2_rdata1",    rdata1, 8'h66);
        chk("t2_rv0_off",   rvalid0, 0);
        tick();
        chk("t2_end_busy",  busy, 0);

        // ---- 3: both continuous -> bursts of 9, 0,1,0 --------------------
        do_reset();
        run_beats(1, 1, 27, -1, 0, pack_addr(7'd0, 7'd0), pack_addr(7'd1, 7'd0));
        chk("t3_nbeats", beat_q.size(), 27);
        for (int k = 0; k < 27 && k < beat_q.size(); k++) begin
            exp_own = (k >= 9 && k < 18);
            chk($sformatf("t3_own_%0d", k), beat_q[k], exp_own);
        end
        chk("t3_n_ret0", ret0_q.size(), 18);
        chk("t3_n_ret1", ret1_q.size(), 9);
        errs = 0;
        for (int k = 0; k < ret0_q.size(); k++)
            if (ret0_q[k] !== (8'(k) ^ 8'hA5)) errs++;
        chk("t3_order0", errs, 0);
        errs = 0;
        for (int k = 0; k < ret1_q.size(); k++)
            if (ret1_q[k] !== (8'(8'h80 + k) ^ 8'hA5)) errs++;
        chk("t3_order1", errs, 0);

        // ---- 4: stall mid-burst does not count or switch -----------------
        do_reset();
        run_beats(1, 1, 18, 4, 3, pack_addr(7'd0, 7'd0), pack_addr(7'd1, 7'd0));
        chk("t4_nbeats", beat_q.size(), 18);
        errs = 0;
        for (int k = 0; k < beat_q.size(); k++)
            if (beat_q[k] != (k >= 9)) errs++;
        chk("t4_burst9", errs, 0);
        chk("t4_n_ret0", ret0_q.size(), 9);
        if (ret0_q.size() > 4) chk("t4_ret0_4", ret0_q[4], 8'h04 ^ 8'hA5);
        else                   chk("t4_ret0_4", ret0_q.size(), 5);

        // ---- 5: lone requester keeps ownership -------------------------
        do_reset();
        run_beats(0, 1, 20, -1, 0, '0, pack_addr(7'd2, 7'd0));
        chk("t5_nbeats", beat_q.size(), 20);
        errs = 0;
        for (int k = 0; k < beat_q.size(); k++)
            if (beat_q[k] != 1'b1) errs++;
        chk("t5_all_port1", errs, 0);
        chk("t5_n_ret1", ret1_q.size(), 20);
        if (ret1_q.size() == 20) chk("t5_last", ret1_q[19], 8'hB6);

        // ---- 6: reset right after an accepted beat -----------------------
        do_reset();
        req0 = 1'b1; addr0 = 14'h0005;
        tick(); tick();                      // OWN0, beat accepted
        req0 = 1'b0;
        tick(); tick();                      // back to IDLE, last owner = 0
        req0 = 1'b1; addr0 = 14'h0006;
        tick(); tick();                      // OWN0, beat accepted
        reset = 1'b1; req0 = 1'b0;
        tick();
        chk("t6_rst_rvalid", {rvalid1, rvalid0}, 2'b00);
        chk("t6_rst_gnt",    {gnt1, gnt0}, 2'b00);
        chk("t6_rst_busy",   busy, 0);
        reset = 1'b0;
        tick();
        chk("t6_no_late_rv", rvalid0, 0);
        req0 = 1'b1; req1 = 1'b1; addr0 = 14'h0010; addr1 = 14'h0020;
        tick();
        chk("t6_tie_port0",  {gnt1, gnt0}, 2'b01);
        req0 = 1'b0; req1 = 1'b0;
        repeat (3) tick();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
